// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Cleans up the four raw push buttons for the Simon game core. Each channel
//   is synchronised, then debounced with a per-channel stability counter.
//   The block produces debounced levels and single-cycle press/release pulses.
//   An encoder then turns presses into a single-press event or a
//   multi-press error.
//
// Ports
//   clk          game clock (25 MHz)
//   rst          synchronous active-high reset
//   btn_raw      raw asynchronous buttons, bit i = BTNi
//   btn_level    debounced level per button
//   btn_press    one-cycle pulse on a debounced 0->1 transition
//   btn_release  one-cycle pulse on a debounced 1->0 transition
//   press_valid  one-cycle pulse: exactly one clean new press
//   press_code   index of the pressed button (valid with press_valid)
//   multi_err    one-cycle pulse: simultaneous press, or press while another held
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int TICKS_PER_MS = 25000,
  parameter int DEBOUNCE_MS  = 10,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic       multi_err
);

  localparam int N  = TICKS_PER_MS * DEBOUNCE_MS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  // Number of set bits in a 4-bit vector.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Index of the single set bit of a one-hot vector (0 otherwise).
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    case (v)
      4'b0001: onehot_index = 2'd0;
      4'b0010: onehot_index = 2'd1;
      4'b0100: onehot_index = 2'd2;
      4'b1000: onehot_index = 2'd3;
      default: onehot_index = 2'd0;
    endcase
  endfunction

  logic [3:0]    sync_r [SYNC_STAGES];
  logic [3:0]    sync_s;
  logic [CW-1:0] cnt_r [4];
  logic [CW-1:0] cnt_nxt_s [4];
  logic [3:0]    level_nxt_s;
  logic          valid_nxt_s;
  logic          err_nxt_s;
  logic [1:0]    code_nxt_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous raw inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= 4'b0000;
      end
    end else begin
      sync_r[0] <= btn_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // Debounce decision: any agreement clears the count. The level follows
  // only after N consecutive disagreeing cycles.
  always_comb begin
    level_nxt_s = btn_level;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (sync_s[i] == btn_level[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_LAST) begin
        level_nxt_s[i] = sync_s[i];
        cnt_nxt_s[i]   = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
      end
    end
  end

  // Counters, debounced level and edge pulses (pulses share the level's edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
      end
      btn_level   <= 4'b0000;
      btn_press   <= 4'b0000;
      btn_release <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      btn_level   <= level_nxt_s;
      btn_press   <= level_nxt_s & ~btn_level;
      btn_release <= ~level_nxt_s & btn_level;
    end
  end

  // Event encoder. btn_level already includes the new press here, so any
  // other set level bit means another button is still held.
  always_comb begin
    valid_nxt_s = 1'b0;
    err_nxt_s   = 1'b0;
    code_nxt_s  = 2'd0;
    if ((popcount4(btn_press) == 3'd1) && ((btn_level & ~btn_press) == 4'b0000)) begin
      valid_nxt_s = 1'b1;
      code_nxt_s  = onehot_index(btn_press);
    end else if (btn_press != 4'b0000) begin
      err_nxt_s = 1'b1;
    end else begin
      valid_nxt_s = 1'b0;
    end
  end

  // Registered encoder outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_valid <= 1'b0;
      press_code  <= 2'd0;
      multi_err   <= 1'b0;
    end else begin
      press_valid <= valid_nxt_s;
      press_code  <= code_nxt_s;
      multi_err   <= err_nxt_s;
    end
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Four-channel push-button conditioner that sits directly upstream of the Simon game core. It converts the raw, asynchronous, bouncing BTN0..BTN3 board inputs into clean, synchronised, debounced levels, plus single-cycle press/release pulses. It also produces an encoded single-press event that the game FSM and pixel generator consume. It runs on the divided 25 MHz game clock.

## Interface

Parameters:
- TICKS_PER_MS, 25000, clock cycles per millisecond (25 MHz).
- DEBOUNCE_MS, 10, required stable time in ms.
- SYNC_STAGES, 2, synchroniser flip-flop depth (min 2).

Ports:
- clk  input  1  game clock (divided 25 MHz).
- rst  input  1  reset; one clock, synchronous, active-high.
- btn_raw  input  4  raw buttons, bit i = BTNi, asynchronous, active-high.
- btn_level  output  4  debounced level per button.
- btn_press  output  4  one-cycle pulse on the debounced 0->1 transition.
- btn_release  output  4  one-cycle pulse on the debounced 1->0 transition.
- press_valid  output  1  one-cycle pulse: exactly one clean new press.
- press_code  output  2  index of the pressed button; valid only while press_valid=1.
- multi_err  output  1  one-cycle pulse: an illegal simultaneous press.

## Operation

- N = DEBOUNCE_MS*TICKS_PER_MS. The counter width is clog2(N+1); no wrap is possible, because the counter is cleared on reaching N-1.
- Per channel:
  - An SYNC_STAGES-deep flip-flop chain produces sync[i].
  - Per channel there is one counter cnt[i] and one state bit btn_level[i].
- Debounce rule, evaluated at every clk edge per channel:
  - If sync[i]==btn_level[i]: cnt[i] <= 0.
  - Else if cnt[i]==N-1: btn_level[i] <= sync[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Consequence: any mismatch run shorter than N cycles produces no output change. A bounce resets the count.
- Edge pulses, registered at the same edge that flips btn_level[i]:
  - btn_press[i]=1 when btn_level[i] goes 0->1.
  - btn_release[i]=1 when btn_level[i] goes 1->0.
  - Each pulse lasts exactly one cycle.
- Event encoder, registered one cycle after btn_press:
  - Let P = btn_press and L = btn_level, both sampled in the same cycle.
  - If popcount(P)==1 and (L & ~P)==0:
    - press_valid=1.
    - press_code = index of the set bit of P.
  - Else if P!=0: multi_err=1, press_valid=0, press_code=0.
    - This covers two or more simultaneous presses.
    - It also covers a new press while another button is still held.
  - Else: press_valid=0, multi_err=0, press_code=0.
- Channels are fully independent up to the encoder. Releases never generate press_valid or multi_err.

## Timing

- Reset values: all sync flip-flops, cnt, and btn_level are 0. btn_press, btn_release, press_valid, press_code, and multi_err are 0.
- A reset asserted mid-count discards all progress. The first cycle after reset behaves as a fresh start.
- A button held high through reset is therefore reported as a fresh press after N+SYNC_STAGES cycles. This is intended.
- Latency: btn_raw[i] changes and then stays stable, first sampled at edge 1.
  - sync[i] updates at edge SYNC_STAGES.
  - btn_level[i] and the pulse update at edge SYNC_STAGES+N.
  - press_valid and multi_err assert at edge SYNC_STAGES+N+1, for one cycle.
- Minimum spacing between two press events on the same channel is 2N cycles: N to release plus N to press again.
- Presses on different channels resolving in different cycles are separate events. The second of these is a multi_err if the first button is still held.

## Test plan

All tests use TICKS_PER_MS=4, DEBOUNCE_MS=2 (N=8), SYNC_STAGES=2.

- **Reset:** hold rst for 3 cycles with btn_raw=4'b0000. -> All outputs are 0 during reset and for 20 cycles after.
- **Clean press:** set btn_raw=4'b0100 after reset and hold it.
  - -> btn_level[2] and btn_press=4'b0100 appear at edge 10 (one cycle only).
  - -> press_valid=1 with press_code=2 at edge 11.
  - -> Releasing gives btn_release[2] 10 edges later, with no press_valid.
- **Bounce:** toggle btn_raw[0] high for 5 cycles, low for 2, then hold high.
  - -> No output during the bounce.
  - -> btn_press[0] fires 10 edges after the final rising edge, followed by press_valid with code 0.
- **Simultaneous press:** set btn_raw=4'b0011 in one cycle. -> btn_press=4'b0011 for one cycle, then multi_err=1 for one cycle, and press_valid stays 0.
- **Press while held:**
  - Hold btn1; it resolves and gives press_valid with code 1.
  - Then press btn3 while btn1 stays high.
  - -> btn_press[3] fires, followed by multi_err=1.
- **Reset mid-count:** start btn_raw[1] high, assert rst at count 5, and keep raw high.
  - -> No pulse occurs before reset.
  - -> After rst drops, btn_press[1] fires exactly 10 edges later.
